// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN is consumed by arb_priority_sel.
package mem_bus_pkg;

   localparam int DEF_ADDR_W = 64;
   localparam int DEF_DATA_W = 64;
   // Wide enough for the largest permitted starvation bound (15)
   localparam int STREAK_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Winner select for the shared bus: D-priority with a starvation bound on I,
// or plain round-robin on ties when ARB_ROUND_ROBIN_EN is defined.
module arb_priority_sel
   import mem_bus_pkg::*;
#(
   parameter int MAX_STREAK = 4
)(
   input  logic CLK,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   input  logic grant_en,
   output gnt_t winner
);

`ifdef ARB_ROUND_ROBIN_EN

   gnt_t last_gnt_reg;

   // Ties go to whichever side did not win the previous grant
   always_comb begin
      winner = GNT_D;
      if (i_req && d_req) begin
         winner = (last_gnt_reg == GNT_D) ? GNT_I : GNT_D;
      end else if (i_req) begin
         winner = GNT_I;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         last_gnt_reg <= GNT_D;
      end else if (grant_en) begin
         last_gnt_reg <= winner;
      end
   end

`else

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] streak_reg;
   logic [STREAK_W-1:0] streak_next;

   always_comb begin
      winner = GNT_D;
      if (i_req && (!d_req || streak_reg == STREAK_MAX)) begin
         winner = GNT_I;
      end
   end

   // Count only D grants that actually made a pending I request wait
   always_comb begin
      streak_next = streak_reg;
      if (grant_en) begin
         if (winner == GNT_I || !i_req) begin
            streak_next = '0;
         end else if (streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + STREAK_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         streak_reg <= '0;
      end else begin
         streak_reg <= streak_next;
      end
   end

`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter/sequencer for the shared memory bus between I-side and D-side.
// Build macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MAX_STREAK = 4
)(
   input  logic              CLK,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            state_reg, state_next;
   gnt_t              gnt_reg, gnt_next;
   gnt_t              winner;
   logic              grant_en;
   logic              mem_req_reg, mem_req_next;
   logic              mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic              i_done_reg, i_done_next;
   logic              d_done_reg, d_done_next;
   logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
   logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

   assign grant_en = (state_reg == ST_IDLE) && (i_req || d_req);

   arb_priority_sel #(
      .MAX_STREAK (MAX_STREAK)
   ) u_sel (
      .CLK      (CLK),
      .reset    (reset),
      .i_req    (i_req),
      .d_req    (d_req),
      .grant_en (grant_en),
      .winner   (winner)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         gnt_reg       <= GNT_D;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         i_done_reg    <= 1'b0;
         d_done_reg    <= 1'b0;
         i_rdata_reg   <= '0;
         d_rdata_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         gnt_reg       <= gnt_next;
         mem_req_reg   <= mem_req_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         i_done_reg    <= i_done_next;
         d_done_reg    <= d_done_next;
         i_rdata_reg   <= i_rdata_next;
         d_rdata_reg   <= d_rdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      gnt_next       = gnt_reg;
      mem_req_next   = mem_req_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      i_done_next    = 1'b0;
      d_done_next    = 1'b0;
      i_rdata_next   = i_rdata_reg;
      d_rdata_next   = d_rdata_reg;

      case (state_reg)
         ST_IDLE: begin
            if (grant_en) begin
               gnt_next     = winner;
               mem_req_next = 1'b1;
               state_next   = ST_BUSY;
               if (winner == GNT_D) begin
                  mem_we_next    = d_we;
                  mem_addr_next  = d_addr;
                  mem_wdata_next = d_wdata;
               end else begin
                  mem_we_next    = 1'b0;
                  mem_addr_next  = i_addr;
                  mem_wdata_next = '0;
               end
            end
         end
         ST_BUSY: begin
            // Requests are deliberately ignored here; the granted side completes
            if (mem_ack) begin
               mem_req_next = 1'b0;
               state_next   = ST_DONE;
               if (gnt_reg == GNT_D) begin
                  d_rdata_next = mem_rdata;
                  d_done_next  = 1'b1;
               end else begin
                  i_rdata_next = mem_rdata;
                  i_done_next  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign i_done    = i_done_reg;
   assign d_done    = d_done_reg;
   assign i_rdata   = i_rdata_reg;
   assign d_rdata   = d_rdata_reg;
   assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected bus transactions are queued in
// predicted grant order and compared as the DUT issues and completes them.
module tb_mem_bus_arbiter;

   typedef struct packed {
      logic        side;   // 0 = I, 1 = D
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
   } txn_t;

   logic        CLK = 1'b0;
   logic        reset;
   logic        i_req;
   logic [63:0] i_addr;
   logic        i_done;
   logic [63:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_done;
   logic [63:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic        busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   txn_t exp_q[$];

   int   fixed_delay = -1;
   int   stray_req = 0;
   int   stray_done = 0;
   int   mem_cnt = 0;
   int   mem_dly = 0;
   bit   mem_was_req = 0;

   txn_t        cur;
   bit          active = 0;
   int          since_ack = -1;
   bit          prev_req = 0;
   logic [63:0] last_rd [2];

   always #5 CLK = ~CLK;

   mem_bus_arbiter dut (
      .CLK       (CLK),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_done    (i_done),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] mem_data(input logic [63:0] a);
      if (a == 64'h1000) return 64'h0000_0000_0050_0093;
      return {~a[31:0], a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   function automatic txn_t i_txn(input logic [63:0] base, input int k);
      txn_t t;
      t.side  = 1'b0;
      t.addr  = base + 64'(k) * 64'd64;
      t.we    = 1'b0;
      t.wdata = '0;
      return t;
   endfunction

   // Even indices write, odd indices read
   function automatic txn_t d_txn(input logic [63:0] base, input int k);
      txn_t t;
      t.side  = 1'b1;
      t.addr  = base + 64'(k) * 64'd8;
      t.we    = (k % 2 == 0);
      t.wdata = 64'hDEAD_BEEF + 64'(k) * 64'h1_0000_0000;
      return t;
   endfunction

   task automatic push(input txn_t t);
      exp_q.push_back(t);
   endtask

   task automatic wait_done(input bit side);
      int t = 0;
      bit seen = 0;
      do begin
         @(negedge CLK);
         t++;
         seen = side ? d_done : i_done;
      end while (!seen && t < 300);
      if (!seen) check_val(side ? "d_done_timeout" : "i_done_timeout", 0, 1);
   endtask

   task automatic run_i(input logic [63:0] base, input int k0, input int n);
      for (int k = k0; k < k0 + n; k++) begin
         txn_t t = i_txn(base, k);
         i_addr = t.addr;
         i_req  = 1'b1;
         wait_done(1'b0);
         i_req  = 1'b0;
      end
   endtask

   task automatic run_d(input logic [63:0] base, input int k0, input int n);
      for (int k = k0; k < k0 + n; k++) begin
         txn_t t = d_txn(base, k);
         d_addr  = t.addr;
         d_we    = t.we;
         d_wdata = t.wdata;
         d_req   = 1'b1;
         wait_done(1'b1);
         d_req   = 1'b0;
      end
   endtask

   // Memory model: responds a fixed or random number of cycles after mem_req
   initial begin : memory
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge CLK);
         #1;
         mem_ack = 1'b0;
         if (reset) begin
            mem_cnt     = 0;
            mem_was_req = 0;
         end else if (mem_req) begin
            if (!mem_was_req) begin
               mem_dly     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
               mem_cnt     = 0;
               mem_was_req = 1;
            end
            if (mem_cnt == mem_dly) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_data(mem_addr);
            end
            mem_cnt++;
         end else begin
            mem_was_req = 0;
            if (stray_done != stray_req) begin
               mem_ack   = 1'b1;
               mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
               stray_done++;
            end
         end
      end
   end

   initial begin : monitor
      last_rd[0] = '0;
      last_rd[1] = '0;
      forever begin
         @(negedge CLK);
         if (reset) begin
            active     = 0;
            since_ack  = -1;
            prev_req   = 0;
            last_rd[0] = '0;
            last_rd[1] = '0;
         end else begin
            if (since_ack == 2) begin
               check_val("busy_after_done", busy, 0);
               since_ack = -1;
            end
            if (i_done || d_done) begin
               logic [63:0] rd;
               rd = mem_data(cur.addr);
               check_val("done_timing", 64'(since_ack), 1);
               check_val("done_active", active, 1);
               check_val("done_excl", i_done & d_done, 0);
               check_val("done_side", d_done, cur.side);
               if (cur.side) begin
                  if (!cur.we) check_val("d_rdata", d_rdata, rd);
                  check_val("i_rdata_hold", i_rdata, last_rd[0]);
                  last_rd[1] = rd;
               end else begin
                  check_val("i_rdata", i_rdata, rd);
                  check_val("d_rdata_hold", d_rdata, last_rd[1]);
                  last_rd[0] = rd;
               end
               $display("txn done side=%s addr=0x%0h we=%0d", cur.side ? "D" : "I", cur.addr, cur.we);
               active = 0;
            end
            if (since_ack == 1) begin
               check_val("done_pulse", i_done | d_done, 1);
               check_val("req_dropped", mem_req, 0);
               check_val("busy_in_done", busy, 1);
               since_ack = 2;
            end
            if (mem_req && !prev_req) begin
               if (exp_q.size() == 0) begin
                  check_val("unexpected_req", 1, 0);
               end else begin
                  cur = exp_q.pop_front();
                  check_val("grant_addr", mem_addr, cur.addr);
                  check_val("grant_we", mem_we, cur.we);
                  check_val("grant_wdata", mem_wdata, cur.wdata);
               end
               active = 1;
            end
            if (mem_req && mem_ack) begin
               check_val("hold_addr", mem_addr, cur.addr);
               check_val("hold_we", mem_we, cur.we);
               check_val("hold_wdata", mem_wdata, cur.wdata);
               check_val("busy_in_busy", busy, 1);
               since_ack = 1;
            end
            prev_req = mem_req;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      reset   = 1'b1;
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_i_done", i_done, 0);
      check_val("rst_d_done", d_done, 0);
      check_val("rst_i_rdata", i_rdata, 0);
      check_val("rst_d_rdata", d_rdata, 0);
      check_val("rst_busy", busy, 0);
      reset = 1'b0;

      // I-only read, ack two cycles after mem_req
      fixed_delay = 2;
      push(i_txn(64'h1000, 0));
      @(negedge CLK);
      run_i(64'h1000, 0, 1);

      // D write held until a late ack, then a D read
      fixed_delay = 3;
      push(d_txn(64'h2008, 0));
      @(negedge CLK);
      run_d(64'h2008, 0, 1);
      fixed_delay = 0;
      push(d_txn(64'h4000, 1));
      @(negedge CLK);
      run_d(64'h4000, 1, 1);

      // Simultaneous first arbitration
      fixed_delay = -1;
`ifdef ARB_ROUND_ROBIN_EN
      push(i_txn(64'h5000, 0));
      push(d_txn(64'h6000, 0));
`else
      push(d_txn(64'h6000, 0));
      push(i_txn(64'h5000, 0));
`endif
      @(negedge CLK);
      fork
         run_i(64'h5000, 0, 1);
         run_d(64'h6000, 0, 1);
      join

      // Continuous contention: 2 I requests against 8 back-to-back D requests
`ifdef ARB_ROUND_ROBIN_EN
      push(i_txn(64'h7000, 0));
      push(d_txn(64'h8000, 0));
      push(i_txn(64'h7000, 1));
      for (int k = 1; k < 8; k++) push(d_txn(64'h8000, k));
`else
      for (int k = 0; k < 4; k++) push(d_txn(64'h8000, k));
      push(i_txn(64'h7000, 0));
      for (int k = 4; k < 8; k++) push(d_txn(64'h8000, k));
      push(i_txn(64'h7000, 1));
`endif
      @(negedge CLK);
      fork
         run_i(64'h7000, 0, 2);
         run_d(64'h8000, 0, 8);
      join

      // Reset while BUSY with the ack still outstanding
      fixed_delay = 1000;
      push(i_txn(64'h3000, 0));
      @(negedge CLK);
      i_addr = i_txn(64'h3000, 0).addr;
      i_req  = 1'b1;
      begin
         int t = 0;
         do begin
            @(negedge CLK);
            t++;
         end while (!mem_req && t < 20);
         check_val("abort_req_seen", mem_req, 1);
      end
      @(posedge CLK);
      #3;
      reset = 1'b1;
      i_req = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check_val("abort_mem_req", mem_req, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_no_done", i_done | d_done, 0);
      #1;
      reset       = 1'b0;
      fixed_delay = -1;
      stray_req++;
      repeat (4) begin
         @(negedge CLK);
         check_val("stray_no_done", i_done | d_done, 0);
         check_val("stray_no_req", mem_req, 0);
         check_val("stray_idle", busy, 0);
      end
      push(i_txn(64'h3000, 1));
      run_i(64'h3000, 1, 1);

      repeat (4) @(negedge CLK);
      check_val("scoreboard_empty", 64'(exp_q.size()), 0);
      check_val("no_open_txn", active, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
